// File: rtl/conv_encoder_frame.sv
// conv_encoder_frame: frame-based convolutional encoder, rate 1/N, constraint length K.
// Takes information bits over a valid/ready handshake and emits one N-bit code symbol
// per bit. It appends K-1 zero tail bits so the encoder returns to state 0, then
// pulses o_done. Generator polynomials and frame length are latched at frame start.
module conv_encoder_frame #(
  parameter int CONSTRAINT_LENGTH = 9,
  parameter int CODE_RATE         = 3,
  parameter int FRAME_LEN_W       = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CODE_RATE*CONSTRAINT_LENGTH-1:0] i_gen_poly,
  input  logic [FRAME_LEN_W-1:0]                 i_frame_len,
  input  logic                                   i_start,
  input  logic                                   i_bit,
  input  logic                                   i_bit_valid,
  output logic                                   o_bit_ready,
  output logic [CODE_RATE-1:0]                   o_data,
  output logic                                   o_data_valid,
  input  logic                                   i_data_ready,
  output logic                                   o_busy,
  output logic                                   o_done
);

  localparam int K  = CONSTRAINT_LENGTH;
  localparam int N  = CODE_RATE;
  localparam int CW = FRAME_LEN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_TAIL,
    ST_FLUSH
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [K-2:0]           sreg;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_inc;
  logic [CW-1:0]          data_end;
  logic [CW-1:0]          tail_end;
  logic [N*K-1:0]         poly_q;
  logic [FRAME_LEN_W-1:0] len_q;
  logic                   free;
  logic                   accept;
  logic                   inject;
  logic                   load;
  logic                   enc_bit;
  logic                   done_nxt;
  logic [K-1:0]           mux;
  logic [N-1:0]           enc;

  // Output slot can take a new symbol if empty or being drained this cycle
  assign free     = !o_data_valid || i_data_ready;
  assign cnt_inc  = cnt + 1'b1;
  assign data_end = {1'b0, len_q};
  assign tail_end = {1'b0, len_q} + CW'(K - 1);
  assign load     = accept || inject;
  // Tail cycles feed a zero into the encoder instead of the input bit
  assign enc_bit  = accept ? i_bit : 1'b0;
  assign mux      = {sreg, enc_bit};
  assign o_busy   = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state, handshake and control decode
  always_comb begin
    state_nxt   = state;
    o_bit_ready = 1'b0;
    accept      = 1'b0;
    inject      = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = (i_frame_len == '0) ? ST_TAIL : ST_DATA;
      end
      ST_DATA: begin
        o_bit_ready = free;
        accept      = i_bit_valid && free;
        if (accept && (cnt_inc == data_end)) state_nxt = ST_TAIL;
      end
      ST_TAIL: begin
        inject = free;
        if (inject && (cnt_inc == tail_end)) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (o_data_valid && i_data_ready) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-polynomial parity of the tapped window
  always_comb begin
    enc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      enc[i] = ^(mux & poly_q[i*K +: K]);
    end
  end

  // Frame configuration latch, shift register and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg   <= '0;
      cnt    <= '0;
      poly_q <= '0;
      len_q  <= '0;
    end else if (state == ST_IDLE) begin
      if (i_start) begin
        poly_q <= i_gen_poly;
        len_q  <= i_frame_len;
        sreg   <= '0;
        cnt    <= '0;
      end
    end else if (load) begin
      sreg <= mux[K-2:0];
      cnt  <= cnt_inc;
    end
  end

  // One-deep output register and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_done <= done_nxt;
      if (load) begin
        o_data       <= enc;
        o_data_valid <= 1'b1;
      end else if (i_data_ready) begin
        o_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_frame.sv
// Testbench for conv_encoder_frame: a K=3/N=2 and a K=9/N=3 instance, each checked
// against a convolution reference model over the zero-padded bit sequence.
module tb_conv_encoder_frame;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [26:0] gen = '0;
  logic [15:0] i_frame_len = '0;
  logic        i_start = 1'b0;
  logic        i_bit = 1'b0;
  logic        i_bit_valid = 1'b0;
  logic        i_data_ready = 1'b0;

  logic       r3, v3, b3, d3;
  logic [1:0] data3;
  logic       r9, v9, b9, d9;
  logic [2:0] data9;

  logic       m_ready, m_valid, m_busy, m_done;
  logic [2:0] m_data;

  int n_cmp = 0;
  int n_err = 0;
  bit tb_bits[$];
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  conv_encoder_frame #(.CONSTRAINT_LENGTH(3), .CODE_RATE(2), .FRAME_LEN_W(16)) dut3 (
    .clk(clk), .rst(rst), .i_gen_poly(gen[5:0]), .i_frame_len(i_frame_len),
    .i_start(i_start && !sel), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
    .o_bit_ready(r3), .o_data(data3), .o_data_valid(v3), .i_data_ready(i_data_ready),
    .o_busy(b3), .o_done(d3)
  );

  conv_encoder_frame #(.CONSTRAINT_LENGTH(9), .CODE_RATE(3), .FRAME_LEN_W(16)) dut9 (
    .clk(clk), .rst(rst), .i_gen_poly(gen), .i_frame_len(i_frame_len),
    .i_start(i_start && sel), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
    .o_bit_ready(r9), .o_data(data9), .o_data_valid(v9), .i_data_ready(i_data_ready),
    .o_busy(b9), .o_done(d9)
  );

  assign m_ready = sel ? r9 : r3;
  assign m_valid = sel ? v9 : v3;
  assign m_busy  = sel ? b9 : b3;
  assign m_done  = sel ? d9 : d3;
  assign m_data  = sel ? data9 : {1'b0, data3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Runs one frame on instance s; tb_bits holds the information bits.
  task automatic run_frame(input int s, input int k, input int n, input logic [26:0] poly,
                           input int len, input int vmode, input int rpct,
                           input int stall_after, input int abort_after, input int mid_start);
    int total, sx, bx, cyc, first_x, last_x, done_cyc, stall_left, p;
    bit hold_v;
    logic [2:0] hold_d;
    logic [2:0] e;
    exp_q = {};
    total = len + k - 1;
    for (int j = 0; j < total; j++) begin
      e = '0;
      for (int i = 0; i < n; i++) begin
        p = 0;
        for (int t = 0; t < k; t++)
          if (j - t >= 0 && j - t < len) p = p ^ int'(tb_bits[j-t] & poly[i*k+t]);
        e[i] = p[0];
      end
      exp_q.push_back(e);
    end

    @(posedge clk); #1;
    sel = (s == 1);
    gen = poly;
    i_frame_len = 16'(len);
    i_start = 1'b1;
    i_bit_valid = 1'b0;
    i_data_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;

    sx = 0; bx = 0; cyc = 0; done_cyc = -1; first_x = -1; last_x = -1;
    stall_left = 0; hold_v = 0; hold_d = '0;
    while (done_cyc < 0 && cyc < 400) begin
      i_bit = (bx < len) ? tb_bits[bx] : 1'($urandom_range(0, 1));
      case (vmode)
        0:       i_bit_valid = 1'b1;
        1:       i_bit_valid = (cyc % 2 == 0);
        default: i_bit_valid = 1'($urandom_range(0, 1));
      endcase
      if (stall_left > 0) begin
        i_data_ready = 1'b0;
        stall_left--;
      end else begin
        i_data_ready = (int'($urandom_range(1, 100)) <= rpct);
      end
      if (cyc == mid_start) begin
        i_start = 1'b1;
        gen = ~poly;
        i_frame_len = 16'(len + 3);
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      if (hold_v) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(hold_d));
      end
      if (m_valid && !i_data_ready) chk("stall_ready", 32'(m_ready), 32'd0);
      if (bx >= len) chk("ready_after_data", 32'(m_ready), 32'd0);
      chk("busy", 32'(m_busy), 32'(!m_done));
      if (m_done) begin
        done_cyc = cyc;
        chk("done_count", 32'(sx), 32'(total));
        chk("done_gap", 32'(cyc), 32'(last_x + 1));
      end
      if (m_valid && i_data_ready) begin
        if (sx < total) chk("sym", 32'(m_data), 32'(exp_q[sx]));
        else            chk("extra_sym", 32'(sx + 1), 32'(total));
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        sx++;
        if (sx == stall_after) stall_left = 3;
      end
      hold_v = m_valid && !i_data_ready;
      hold_d = m_data;
      if (m_ready && i_bit_valid) bx++;
      cyc++;
      if (abort_after >= 0 && sx == abort_after) break;
      @(posedge clk); #1;
    end
    i_start = 1'b0;

    if (abort_after >= 0) begin
      @(posedge clk); #1;
      rst = 1'b1;
      i_bit_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk("abort_done", 32'(m_done), 32'd0);
        chk("abort_busy", 32'(m_busy), 32'd0);
      end
    end else begin
      if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
      chk("sym_total", 32'(sx), 32'(total));
      if (vmode == 0 && rpct == 100 && stall_after < 0)
        chk("back_to_back", 32'(last_x - first_x), 32'(total - 1));
      @(posedge clk); #1;
      i_bit_valid = 1'b0;
      gen = poly;
      @(negedge clk);
      chk("done_pulse_end", 32'(m_done), 32'd0);
      chk("idle_busy", 32'(m_busy), 32'd0);
      chk("idle_valid", 32'(m_valid), 32'd0);
    end
  endtask

  task automatic set_bits_1011();
    tb_bits = {1'b1, 1'b0, 1'b1, 1'b1};
  endtask

  initial begin
    logic [26:0] pr;
    int len;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data3", 32'(data3), 32'd0);
    chk("rst_valid3", 32'(v3), 32'd0);
    chk("rst_ready3", 32'(r3), 32'd0);
    chk("rst_busy3", 32'(b3), 32'd0);
    chk("rst_done3", 32'(d3), 32'd0);
    chk("rst_data9", 32'(data9), 32'd0);
    chk("rst_valid9", 32'(v9), 32'd0);
    chk("rst_busy9", 32'(b9), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic K=3 frame, full throughput
    set_bits_1011();
    run_frame(0, 3, 2, 27'b101111, 4, 0, 100, -1, -1, -1);
    // Same frame, 3-cycle stall while the 2nd symbol is presented
    set_bits_1011();
    run_frame(0, 3, 2, 27'b101111, 4, 0, 100, 1, -1, -1);
    // Empty frame on K=9: only 8 tail symbols, all zero
    tb_bits = {};
    run_frame(1, 9, 3, 27'($urandom), 0, 0, 100, -1, -1, -1);
    // Toggling bit valid
    set_bits_1011();
    run_frame(0, 3, 2, 27'b101111, 4, 1, 100, -1, -1, -1);
    // Abort after two symbols, then a clean frame
    set_bits_1011();
    run_frame(0, 3, 2, 27'b101111, 4, 0, 100, -1, 2, -1);
    set_bits_1011();
    run_frame(0, 3, 2, 27'b101111, 4, 0, 100, -1, -1, -1);
    // Start re-asserted mid-frame with different polynomials
    set_bits_1011();
    run_frame(0, 3, 2, 27'b101111, 4, 0, 100, -1, -1, 2);

    // Randomized frames on both instances
    for (int f = 0; f < 12; f++) begin
      pr = 27'($urandom);
      len = int'($urandom_range(1, 20));
      tb_bits = {};
      for (int b = 0; b < len; b++) tb_bits.push_back(1'($urandom_range(0, 1)));
      if (f % 2 == 0) run_frame(0, 3, 2, pr, len, 2, int'($urandom_range(50, 100)), -1, -1, -1);
      else            run_frame(1, 9, 3, pr, len, 2, int'($urandom_range(50, 100)), -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
